mem_port_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared byte-enabled memory port (wr/rd/byte/addr/wdata in, rdata_v/rdata out). It sits between two masters and the memory's `top` port. Each master sees a simple request/grant interface with its own read-return path. The memory sees one-cycle command pulses and at most one outstanding read.

---
 rtl/mem_port_arbiter_pkg.sv | 34 +++
 rtl/mem_port_arbiter_if.sv | 62 ++++++
 rtl/mem_port_arbiter_rr_pick2.sv | 27 ++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-master memory port arbiter.
//   state_t : sequencer states (IDLE, ISSUE, RWAIT, RRET)
//   cmd_t   : one memory command {wr, byte_en, addr, wdata}
//   ARB_*   : default widths and read timeout
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ARB_AW      = 4;   // word address width of the memory
    localparam int ARB_DW      = 32;  // data width
    localparam int ARB_BW      = 4;   // byte enables, one per data byte
    localparam int ARB_TIMEOUT = 15;  // RWAIT cycles before a read is abandoned

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        RRET  = 2'd3
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [ARB_BW-1:0] byte_en;
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] wdata;
    } cmd_t;

    // Index of the master that is not idx.
    function automatic logic other_master(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two master request/grant/read-return channels and the shared
// memory command port.
//   modport slave  : the arbiter side (takes requests, drives the memory)
//   modport master : the environment side (masters and memory model)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = mem_arb_pkg::ARB_AW,
    parameter int DW = mem_arb_pkg::ARB_DW,
    parameter int BW = mem_arb_pkg::ARB_BW
);
    // master 0
    logic          m0_req;
    logic          m0_wr;
    logic [BW-1:0] m0_byte;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;
    // master 1
    logic          m1_req;
    logic          m1_wr;
    logic [BW-1:0] m1_byte;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;
    // memory port
    logic          mem_wr;
    logic          mem_rd;
    logic [BW-1:0] mem_byte;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rdata_v;
    logic [DW-1:0] mem_rdata;
    // status
    logic          rd_timeout;

    modport slave (
        input  m0_req, m0_wr, m0_byte, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_wr, m1_byte, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_wr, mem_rd, mem_byte, mem_addr, mem_wdata,
        input  mem_rdata_v, mem_rdata,
        output rd_timeout
    );

    modport master (
        output m0_req, m0_wr, m0_byte, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_wr, m1_byte, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_wr, mem_rd, mem_byte, mem_addr, mem_wdata,
        output mem_rdata_v, mem_rdata,
        input  rd_timeout
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin pick. With a single request that master wins; with
// both requesting, the master named by ptr wins.
//   req   : request vector {m1, m0}
//   ptr   : priority pointer (master favoured on a tie)
//   valid : at least one request present
//   idx   : winning master index
// -----------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       valid,
    output logic       idx
);

    always_comb begin
        valid = |req;
        idx   = 1'b0;
        if (req == 2'b11) begin
            idx = ptr;
        end else begin
            idx = req[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Round-robin arbiter and sequencer letting two masters share one memory
// port. A winning command is issued as a single-cycle strobe together with the
// winner's grant; reads then wait (bounded by TIMEOUT) for mem_rdata_v and
// return the data to the owner with a single-cycle rvalid. Every output comes
// straight from a flop.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : master request/grant/read-return channels and memory port
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam int             CW          = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TIMEOUT_CNT = CW'(TIMEOUT);

    state_t            state_reg,      state_next;
    logic              ptr_reg,        ptr_next;
    logic              owner_reg,      owner_next;
    logic [CW-1:0]     cnt_reg,        cnt_next;
    // Holds the command only during ISSUE, so it is both the memory strobe
    // register and the latch that tells ISSUE whether a read follows.
    cmd_t              issue_reg,      issue_next;
    logic              mem_rd_reg,     mem_rd_next;
    logic [1:0]        gnt_reg,        gnt_next;
    logic [1:0]        rvalid_reg,     rvalid_next;
    logic              rd_timeout_reg, rd_timeout_next;

    logic              cap_en;
    logic [ARB_DW-1:0] cap_data;
    logic [CW-1:0]     cnt_inc;

    logic [1:0]        req_vec;
    logic              pick_valid;
    logic              pick_idx;
    cmd_t [1:0]        req_cmd;
    logic [1:0][ARB_DW-1:0] rdata_all;

    assign req_vec    = {bus.m1_req, bus.m0_req};
    assign req_cmd[0] = '{wr: bus.m0_wr, byte_en: bus.m0_byte,
                          addr: bus.m0_addr, wdata: bus.m0_wdata};
    assign req_cmd[1] = '{wr: bus.m1_wr, byte_en: bus.m1_byte,
                          addr: bus.m1_addr, wdata: bus.m1_wdata};
    assign cnt_inc    = cnt_reg + 1'b1;

    rr_pick2 u_pick (
        .req   (req_vec),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so that they are registered yet line up with that state.
    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        owner_next      = owner_reg;
        cnt_next        = cnt_reg;
        issue_next      = '0;
        mem_rd_next     = 1'b0;
        gnt_next        = '0;
        rvalid_next     = '0;
        rd_timeout_next = 1'b0;
        cap_en          = 1'b0;
        cap_data        = '0;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    owner_next         = pick_idx;
                    issue_next         = req_cmd[pick_idx];
                    mem_rd_next        = ~req_cmd[pick_idx].wr;
                    gnt_next[pick_idx] = 1'b1;
                    state_next         = ISSUE;
                end
            end
            ISSUE: begin
                ptr_next = other_master(owner_reg);
                if (issue_reg.wr) begin
                    state_next = IDLE;
                end else begin
                    cnt_next   = '0;
                    state_next = RWAIT;
                end
            end
            RWAIT: begin
                cnt_next = cnt_inc;
                // Data arriving on the last allowed cycle still wins.
                if (bus.mem_rdata_v) begin
                    cap_en                 = 1'b1;
                    cap_data               = bus.mem_rdata;
                    rvalid_next[owner_reg] = 1'b1;
                    state_next             = RRET;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    cap_en                 = 1'b1;
                    cap_data               = '0;
                    rvalid_next[owner_reg] = 1'b1;
                    rd_timeout_next        = 1'b1;
                    state_next             = RRET;
                end
            end
            RRET: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            ptr_reg        <= 1'b0;
            owner_reg      <= 1'b0;
            cnt_reg        <= '0;
            issue_reg      <= '0;
            mem_rd_reg     <= 1'b0;
            gnt_reg        <= '0;
            rvalid_reg     <= '0;
            rd_timeout_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            owner_reg      <= owner_next;
            cnt_reg        <= cnt_next;
            issue_reg      <= issue_next;
            mem_rd_reg     <= mem_rd_next;
            gnt_reg        <= gnt_next;
            rvalid_reg     <= rvalid_next;
            rd_timeout_reg <= rd_timeout_next;
        end
    end

    // Per-master read-data holding registers: only the owner's copy updates,
    // and it keeps its value until that master's next read return.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            logic [ARB_DW-1:0] rdata_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg <= '0;
                end else if (cap_en && (owner_reg == 1'(gi))) begin
                    rdata_reg <= cap_data;
                end
            end
            assign rdata_all[gi] = rdata_reg;
        end
    endgenerate

    assign bus.mem_wr     = issue_reg.wr;
    assign bus.mem_rd     = mem_rd_reg;
    assign bus.mem_byte   = issue_reg.byte_en;
    assign bus.mem_addr   = issue_reg.addr;
    assign bus.mem_wdata  = issue_reg.wdata;
    assign bus.m0_gnt     = gnt_reg[0];
    assign bus.m1_gnt     = gnt_reg[1];
    assign bus.m0_rvalid  = rvalid_reg[0];
    assign bus.m1_rvalid  = rvalid_reg[1];
    assign bus.m0_rdata   = rdata_all[0];
    assign bus.m1_rdata   = rdata_all[1];
    assign bus.rd_timeout = rd_timeout_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench: a table of {inputs, expected outputs} rows applied one clock
// each, followed by hand-written sequences for timeout, late-data priority and
// reset during a read.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        m0_req;
        logic        m0_wr;
        logic [3:0]  m0_byte;
        logic [3:0]  m0_addr;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic        m1_wr;
        logic [3:0]  m1_byte;
        logic [3:0]  m1_addr;
        logic [31:0] m1_wdata;
        logic        mem_rdata_v;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        mem_wr;
        logic        mem_rd;
        logic [3:0]  mem_byte;
        logic [3:0]  mem_addr;
        logic [31:0] mem_wdata;
        logic        m0_gnt;
        logic        m1_gnt;
        logic        m0_rvalid;
        logic        m1_rvalid;
        logic [31:0] m0_rdata;
        logic [31:0] m1_rdata;
        logic        rd_timeout;
    } out_t;

    typedef struct packed {
        in_t  stim;
        out_t exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    vec_t vecs[$];

    mem_port_arbiter_if #(.AW(4), .DW(32), .BW(4)) bus ();

    mem_port_arbiter #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(
        input logic a_req, input logic a_wr, input logic [3:0] a_byte,
        input logic [3:0] a_addr, input logic [31:0] a_wdata,
        input logic b_req, input logic b_wr, input logic [3:0] b_byte,
        input logic [3:0] b_addr, input logic [31:0] b_wdata,
        input logic rv, input logic [31:0] rd);
        return '{m0_req: a_req, m0_wr: a_wr, m0_byte: a_byte, m0_addr: a_addr,
                 m0_wdata: a_wdata, m1_req: b_req, m1_wr: b_wr, m1_byte: b_byte,
                 m1_addr: b_addr, m1_wdata: b_wdata, mem_rdata_v: rv, mem_rdata: rd};
    endfunction

    function automatic out_t mk_out(
        input logic wr, input logic rd, input logic [3:0] be, input logic [3:0] addr,
        input logic [31:0] wdata, input logic g0, input logic g1, input logic v0,
        input logic v1, input logic [31:0] r0, input logic [31:0] r1, input logic to);
        return '{mem_wr: wr, mem_rd: rd, mem_byte: be, mem_addr: addr, mem_wdata: wdata,
                 m0_gnt: g0, m1_gnt: g1, m0_rvalid: v0, m1_rvalid: v1,
                 m0_rdata: r0, m1_rdata: r1, rd_timeout: to};
    endfunction

    function automatic out_t sample();
        return '{mem_wr: bus.mem_wr, mem_rd: bus.mem_rd, mem_byte: bus.mem_byte,
                 mem_addr: bus.mem_addr, mem_wdata: bus.mem_wdata,
                 m0_gnt: bus.m0_gnt, m1_gnt: bus.m1_gnt,
                 m0_rvalid: bus.m0_rvalid, m1_rvalid: bus.m1_rvalid,
                 m0_rdata: bus.m0_rdata, m1_rdata: bus.m1_rdata,
                 rd_timeout: bus.rd_timeout};
    endfunction

    task automatic drive(input in_t v);
        bus.m0_req      = v.m0_req;
        bus.m0_wr       = v.m0_wr;
        bus.m0_byte     = v.m0_byte;
        bus.m0_addr     = v.m0_addr;
        bus.m0_wdata    = v.m0_wdata;
        bus.m1_req      = v.m1_req;
        bus.m1_wr       = v.m1_wr;
        bus.m1_byte     = v.m1_byte;
        bus.m1_addr     = v.m1_addr;
        bus.m1_wdata    = v.m1_wdata;
        bus.mem_rdata_v = v.mem_rdata_v;
        bus.mem_rdata   = v.mem_rdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %s ok", name);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input out_t exp);
        chk(name, 128'(sample()), 128'(exp));
    endtask

    // Presents a one-cycle read request from master m and checks the issue cycle.
    task automatic start_read(input logic m, input logic [3:0] addr, input string tag);
        in_t v;
        v = '0;
        if (m) begin
            v.m1_req = 1'b1; v.m1_byte = 4'hF; v.m1_addr = addr;
        end else begin
            v.m0_req = 1'b1; v.m0_byte = 4'hF; v.m0_addr = addr;
        end
        drive(v);
        step();
        chk({tag, "_issue"},
            {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.m0_gnt, bus.m1_gnt},
            {1'b1, 1'b0, addr, ~m, m});
        drive('0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        in_t none;
        in_t both_wr;
        in_t v;
        none    = '0;
        both_wr = mk_in(1, 1, 4'hF, 4'd2, 32'h22, 1, 1, 4'h3, 4'd3, 32'h33, 0, 32'h0);

        // Fairness from reset: both write, grants alternate 0,1,0
        vecs.push_back('{both_wr, mk_out(1, 0, 4'hF, 4'd2, 32'h22, 1, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{both_wr, mk_out(0, 0, 4'h0, 4'd0, 32'h0,  0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{both_wr, mk_out(1, 0, 4'h3, 4'd3, 32'h33, 0, 1, 0, 0, 0, 0, 0)});
        vecs.push_back('{both_wr, mk_out(0, 0, 4'h0, 4'd0, 32'h0,  0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{both_wr, mk_out(1, 0, 4'hF, 4'd2, 32'h22, 1, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{none,    mk_out(0, 0, 4'h0, 4'd0, 32'h0,  0, 0, 0, 0, 0, 0, 0)});
        // m0 write addr 1
        vecs.push_back('{mk_in(1, 1, 4'hF, 4'd1, 32'h11, 0, 0, 4'h0, 4'd0, 32'h0, 0, 32'h0),
                         mk_out(1, 0, 4'hF, 4'd1, 32'h11, 1, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{none, mk_out(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0)});
        // m0 read addr 1; stray data in the ISSUE cycle, real data two cycles after mem_rd
        vecs.push_back('{mk_in(1, 0, 4'hF, 4'd1, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0, 0, 32'h0),
                         mk_out(0, 1, 4'hF, 4'd1, 32'h0, 1, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{mk_in(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0, 1, 32'hDEAD),
                         mk_out(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{none, mk_out(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{mk_in(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0, 1, 32'h11),
                         mk_out(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 1, 0, 32'h11, 0, 0)});
        vecs.push_back('{none, mk_out(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 0, 0, 32'h11, 0, 0)});
        // stray mem_rdata_v in IDLE
        vecs.push_back('{mk_in(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0, 1, 32'hABCD),
                         mk_out(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 0, 0, 32'h11, 0, 0)});
        vecs.push_back('{none, mk_out(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 0, 0, 32'h11, 0, 0)});
        // m1 write with byte=0 is still issued and granted
        vecs.push_back('{mk_in(0, 0, 4'h0, 4'd0, 32'h0, 1, 1, 4'h0, 4'd7, 32'h77, 0, 32'h0),
                         mk_out(1, 0, 4'h0, 4'd7, 32'h77, 0, 1, 0, 0, 32'h11, 0, 0)});
        vecs.push_back('{none, mk_out(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 0, 0, 32'h11, 0, 0)});

        // Reset state
        rst_n = 1'b0;
        drive(none);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_state", mk_out(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stim);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].exp);
        end

        // m1 read with immediate data, then an m1 read that times out
        start_read(1'b1, 4'd5, "m1_rd_ok");
        step();
        bus.mem_rdata_v = 1'b1;
        bus.mem_rdata   = 32'h5A5A5A5A;
        step();
        chk("m1_rd_ok_ret", {bus.m1_rvalid, bus.m1_rdata, bus.m0_rvalid, bus.rd_timeout},
            {1'b1, 32'h5A5A5A5A, 1'b0, 1'b0});
        drive(none);
        step();

        start_read(1'b1, 4'd5, "m1_to");
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("m1_to_wait%0d", i),
                {bus.m0_rvalid, bus.m1_rvalid, bus.rd_timeout, bus.mem_rd}, 4'b0000);
        end
        step();
        chk("m1_to_ret", {bus.rd_timeout, bus.m1_rvalid, bus.m1_rdata, bus.m0_rvalid, bus.m0_rdata},
            {1'b1, 1'b1, 32'h0, 1'b0, 32'h11});
        step();
        chk("m1_to_idle", {bus.rd_timeout, bus.m1_rvalid, bus.m1_rdata}, {1'b0, 1'b0, 32'h0});
        v = mk_in(1, 1, 4'hF, 4'd8, 32'h88, 0, 0, 4'h0, 4'd0, 32'h0, 0, 32'h0);
        drive(v);
        step();
        chk("after_to_gnt", {bus.m0_gnt, bus.mem_wr, bus.mem_addr, bus.mem_wdata},
            {1'b1, 1'b1, 4'd8, 32'h88});
        drive(none);
        step();

        // Data on the 15th RWAIT cycle beats the timeout
        start_read(1'b0, 4'd9, "m0_late");
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("m0_late_wait%0d", i),
                {bus.m0_rvalid, bus.m1_rvalid, bus.rd_timeout}, 3'b000);
        end
        bus.mem_rdata_v = 1'b1;
        bus.mem_rdata   = 32'hCAFE0001;
        step();
        chk("m0_late_ret", {bus.m0_rvalid, bus.m0_rdata, bus.rd_timeout, bus.m1_rvalid},
            {1'b1, 32'hCAFE0001, 1'b0, 1'b0});
        drive(none);
        step();

        // Reset in the middle of a read
        start_read(1'b0, 4'd4, "rst_rd");
        step();
        rst_n = 1'b0;
        #2;
        chk_all("rst_mid_read", mk_out(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus.mem_rdata_v = 1'b1;
        bus.mem_rdata   = 32'h99;
        step();
        chk_all("rst_late_data", mk_out(0, 0, 4'h0, 4'd0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
        v = mk_in(1, 1, 4'hC, 4'd6, 32'h66, 0, 0, 4'h0, 4'd0, 32'h0, 0, 32'h0);
        drive(v);
        step();
        chk_all("rst_next_gnt", mk_out(1, 0, 4'hC, 4'd6, 32'h66, 1, 0, 0, 0, 0, 0, 0));
        drive(none);
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
